jk_bank_arbiter: RTL and testbench

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

---
 rtl/jk_pkg.sv | 35 +++
 rtl/jk_cell.sv | 22 ++
 rtl/jk_bank_arbiter.sv | 107 ++++++++++
 tb/tb_jk_bank_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank arbiter: command encodings, FSM states,
// owner tags and the JK next-state rule used by every cell.
package jk_pkg;

  // {j,k} command encoding
  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } jk_state_e;

  // Requester tag, used both for the priority pointer and the latched owner
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } jk_owner_e;

  // Next value of a JK flop given {j,k} and its current value
  function automatic logic jk_next(input logic [1:0] jk, input logic q);
    case (jk)
      OP_RESET:  return 1'b0;
      OP_SET:    return 1'b1;
      OP_TOGGLE: return ~q;
      default:   return q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK storage cell. Pure storage: {j,k} comes fully decoded from the
// arbiter, so a cell with 00 on its inputs simply holds.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  // JK update; async clear on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= jk_next({j, k}, q);
  end

  assign qb = ~q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Two-requester arbiter in front of a bank of JK cells. One command is in
// flight at a time: IDLE accepts, APPLY drives {j,k} into the addressed cell,
// DONE returns the post-update value to the owner.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_op,
  input  logic [IDXW-1:0]  a_idx,
  output logic             a_done,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_op,
  input  logic [IDXW-1:0]  b_idx,
  output logic             b_done,
  output logic             rsp_q,
  output logic             rsp_err,
  output logic [WIDTH-1:0] q_bank,
  output logic [WIDTH-1:0] qb_bank,
  output logic             busy
);

  jk_state_e       state, state_nxt;
  jk_owner_e       ptr;
  jk_owner_e       own_l;
  logic [1:0]      op_l;
  logic [IDXW-1:0] idx_l;
  logic            in_range;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state, grant and completion decode. Grants are also gated by rst so
  // nothing reads as accepted while reset is held.
  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    a_done    = 1'b0;
    b_done    = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy    = 1'b0;
        a_ready = rst && a_valid && (!b_valid || ptr == OWN_A);
        b_ready = rst && b_valid && (!a_valid || ptr == OWN_B);
        if (a_ready || b_ready) state_nxt = ST_APPLY;
      end
      ST_APPLY: state_nxt = ST_DONE;
      ST_DONE: begin
        a_done    = (own_l == OWN_A);
        b_done    = (own_l == OWN_B);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command capture; the pointer always moves to the requester that lost,
  // which yields strict alternation when both keep asking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= OWN_A;
      own_l <= OWN_A;
      op_l  <= OP_HOLD;
      idx_l <= '0;
    end else if (a_ready) begin
      ptr   <= OWN_B;
      own_l <= OWN_A;
      op_l  <= a_op;
      idx_l <= a_idx;
    end else if (b_ready) begin
      ptr   <= OWN_A;
      own_l <= OWN_B;
      op_l  <= b_op;
      idx_l <= b_idx;
    end
  end

  // Out-of-range indices select no cell, so the bank is untouched
  assign in_range = ({1'b0, idx_l} < (IDXW+1)'(WIDTH));
  assign rsp_q    = (state == ST_DONE) && in_range && q_bank[idx_l];
  assign rsp_err  = (state == ST_DONE) && !in_range;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic sel;
    assign sel = (state == ST_APPLY) && (idx_l == IDXW'(i));
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (sel & op_l[1]),
      .k   (sel & op_l[0]),
      .q   (q_bank[i]),
      .qb  (qb_bank[i])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: a vector table of single-requester
// commands plus hand-written sequences for contention, out-of-range index,
// mid-transaction reset and input changes while a command is in flight.
module tb_jk_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [1:0] a_op = 2'b00, b_op = 2'b00;
  logic [2:0] a_idx = 3'd0, b_idx = 3'd0;

  logic       a_ready, b_ready, a_done, b_done, rsp_q, rsp_err, busy;
  logic [7:0] q_bank, qb_bank;
  logic       a_ready6, b_ready6, a_done6, b_done6, rsp_q6, rsp_err6, busy6;
  logic [5:0] q_bank6, qb_bank6;

  int errs   = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  localparam logic [1:0] HOLD = 2'b00, RST = 2'b01, SET = 2'b10, TOG = 2'b11;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.WIDTH(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_idx(a_idx), .a_done(a_done),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_idx(b_idx), .b_done(b_done),
    .rsp_q(rsp_q), .rsp_err(rsp_err), .q_bank(q_bank), .qb_bank(qb_bank), .busy(busy)
  );

  jk_bank_arbiter #(.WIDTH(6), .IDXW(3)) dut6 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready6), .a_op(a_op), .a_idx(a_idx), .a_done(a_done6),
    .b_valid(b_valid), .b_ready(b_ready6), .b_op(b_op), .b_idx(b_idx), .b_done(b_done6),
    .rsp_q(rsp_q6), .rsp_err(rsp_err6), .q_bank(q_bank6), .qb_bank(qb_bank6), .busy(busy6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // qb must track ~q on every cycle, for both bank sizes
  always @(negedge clk) begin
    if (mon_en) begin
      chk("qb_inv8", {24'd0, qb_bank}, {24'd0, ~q_bank});
      chk("qb_inv6", {26'd0, qb_bank6}, {26'd0, ~q_bank6});
    end
  end

  // Hold reset for two edges, release at a negedge with inputs idle
  task automatic do_reset();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  // One uncontested command, starting and ending at a negedge in IDLE.
  // Inputs are dropped and scrambled during APPLY; the latched copy must win.
  task automatic txn(input string tag, input logic own, input logic [1:0] op,
                     input logic [2:0] idx, input logic [7:0] exp_q, input logic exp_rsp);
    if (!own) begin a_valid = 1'b1; a_op = op; a_idx = idx; b_valid = 1'b0; end
    else      begin b_valid = 1'b1; b_op = op; b_idx = idx; a_valid = 1'b0; end
    #1;
    chk({tag, "_ready"}, {31'd0, own ? b_ready : a_ready}, 32'd1);
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
    @(posedge clk); @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    a_op = ~op; b_op = ~op; a_idx = ~idx; b_idx = ~idx;
    #1;
    chk({tag, "_busy_apply"}, {31'd0, busy}, 32'd1);
    chk({tag, "_rdy_apply"}, {30'd0, a_ready, b_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_done"}, {30'd0, a_done, b_done}, own ? 32'd1 : 32'd2);
    chk({tag, "_q"}, {24'd0, q_bank}, {24'd0, exp_q});
    chk({tag, "_rsp_q"}, {31'd0, rsp_q}, {31'd0, exp_rsp});
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk({tag, "_idle"}, {29'd0, busy, a_done, b_done}, 32'd0);
  endtask

  typedef struct {
    logic       own;
    logic [1:0] op;
    logic [2:0] idx;
    logic [7:0] q;
    logic       rsp;
  } vec_t;

  vec_t vt[16];

  initial begin
    vt[0]  = '{1'b0, SET,  3'd3, 8'h08, 1'b1};
    vt[1]  = '{1'b1, SET,  3'd7, 8'h88, 1'b1};
    vt[2]  = '{1'b0, TOG,  3'd0, 8'h89, 1'b1};
    vt[3]  = '{1'b1, TOG,  3'd3, 8'h81, 1'b0};
    vt[4]  = '{1'b0, HOLD, 3'd0, 8'h81, 1'b1};
    vt[5]  = '{1'b1, RST,  3'd7, 8'h01, 1'b0};
    vt[6]  = '{1'b0, SET,  3'd7, 8'h81, 1'b1};
    vt[7]  = '{1'b0, SET,  3'd1, 8'h83, 1'b1};
    vt[8]  = '{1'b1, SET,  3'd2, 8'h87, 1'b1};
    vt[9]  = '{1'b0, SET,  3'd3, 8'h8F, 1'b1};
    vt[10] = '{1'b1, SET,  3'd4, 8'h9F, 1'b1};
    vt[11] = '{1'b0, SET,  3'd5, 8'hBF, 1'b1};
    vt[12] = '{1'b1, SET,  3'd6, 8'hFF, 1'b1};
    vt[13] = '{1'b1, RST,  3'd2, 8'hFB, 1'b0};
    vt[14] = '{1'b1, TOG,  3'd2, 8'hFF, 1'b1};
    vt[15] = '{1'b1, TOG,  3'd2, 8'hFB, 1'b0};

    // Reset values, with A already asserting valid
    a_valid = 1'b1; a_op = SET; a_idx = 3'd3;
    @(posedge clk); @(negedge clk);
    mon_en = 1'b1;
    chk("rst_q", {24'd0, q_bank}, 32'h00);
    chk("rst_qb", {24'd0, qb_bank}, 32'hFF);
    chk("rst_outs", {25'd0, a_ready, b_ready, a_done, b_done, rsp_q, rsp_err, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table: first command is accepted in the first IDLE cycle after release
    for (int i = 0; i < 16; i++)
      txn($sformatf("vec%0d", i), vt[i].own, vt[i].op, vt[i].idx, vt[i].q, vt[i].rsp);

    // No requests: stay idle, bank holds
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_q", {24'd0, q_bank}, 32'hFB);

    // Contention from reset: A TOGGLE 0 vs B SET 7, alternation A,B,A,B
    rst = 1'b0;
    a_valid = 1'b1; a_op = TOG; a_idx = 3'd0;
    b_valid = 1'b1; b_op = SET; b_idx = 3'd7;
    @(posedge clk); @(negedge clk);
    chk("cont_rst_rdy", {30'd0, a_ready, b_ready}, 32'd0);
    rst = 1'b1;
    begin
      logic [7:0] cq[4];
      logic       cr[4];
      cq[0] = 8'h01; cq[1] = 8'h81; cq[2] = 8'h80; cq[3] = 8'h80;
      cr[0] = 1'b1;  cr[1] = 1'b1;  cr[2] = 1'b0;  cr[3] = 1'b1;
      for (int n = 0; n < 4; n++) begin
        logic w;
        w = n[0];
        #1;
        chk($sformatf("cont%0d_grant", n), {30'd0, a_ready, b_ready}, w ? 32'd1 : 32'd2);
        @(posedge clk); @(negedge clk);
        chk($sformatf("cont%0d_apply_rdy", n), {30'd0, a_ready, b_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk($sformatf("cont%0d_done", n), {30'd0, a_done, b_done}, w ? 32'd1 : 32'd2);
        chk($sformatf("cont%0d_q", n), {24'd0, q_bank}, {24'd0, cq[n]});
        chk($sformatf("cont%0d_rsp", n), {31'd0, rsp_q}, {31'd0, cr[n]});
        @(posedge clk); @(negedge clk);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Out-of-range index on the 6-wide bank; 8-wide bank takes it normally
    do_reset();
    a_valid = 1'b1; a_op = SET; a_idx = 3'd6;
    #1;
    chk("err_ready6", {31'd0, a_ready6}, 32'd1);
    @(posedge clk); @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("err_done6", {31'd0, a_done6}, 32'd1);
    chk("err_rsp_err6", {31'd0, rsp_err6}, 32'd1);
    chk("err_rsp_q6", {31'd0, rsp_q6}, 32'd0);
    chk("err_q6", {26'd0, q_bank6}, 32'h00);
    chk("err_q8", {24'd0, q_bank}, 32'h40);
    chk("err_rsp_err8", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("err_idle6", {31'd0, busy6}, 32'd0);

    // Reset during APPLY aborts the command and clears the bank at once
    do_reset();
    txn("pre_abort", 1'b0, SET, 3'd5, 8'h20, 1'b1);
    a_valid = 1'b1; a_op = SET; a_idx = 3'd1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_q", {24'd0, q_bank}, 32'h00);
    chk("abort_outs", {28'd0, a_ready, a_done, rsp_q, busy}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("abort_no_done", {30'd0, a_done, b_done}, 32'd0);
    chk("abort_q_hold", {24'd0, q_bank}, 32'h00);
    rst = 1'b1;
    txn("post_abort", 1'b0, SET, 3'd1, 8'h02, 1'b1);

    // In-flight command unaffected by owner dropping valid and changing op
    txn("drop_tog", 1'b1, TOG, 3'd4, 8'h12, 1'b1);
    txn("drop_rst", 1'b0, RST, 3'd1, 8'h10, 1'b0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
